// File: rtl/mul_op_sequencer.sv
// mul_op_sequencer: front-end for the repetitive-addition multiplier engine.
// It takes an operand pair over a valid/ready handshake and feeds it to the
// engine: the multiplicand goes out in the engine's ldA cycle and the
// multiplier in its ldB cycle. It then waits for done, captures the product,
// returns it over a second handshake, and re-arms the engine with a restart
// pulse.
// Optional build macro: MUL_TIMEOUT_EN. When defined, a WAIT-state cycle
// counter aborts a hung engine after TIMEOUT cycles and flags res_err.
// Without it, res_err is tied low and WAIT has no time limit.
module mul_op_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 65600
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_prod,
  output logic         res_err,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod,
  output logic         mul_restart
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_LD_A    = 3'd2,
    S_LD_B    = 3'd3,
    S_WAIT    = 3'd4,
    S_RESULT  = 3'd5,
    S_RESTART = 3'd6
  } state_t;

  state_t       r_state, w_state_next;
  logic [W-1:0] r_a, w_a_next;
  logic [W-1:0] r_b, w_b_next;
  logic         r_used, w_used_next;       // engine involved in this transaction
  logic         r_op_ready, w_op_ready_next;
  logic         r_res_valid, w_res_valid_next;
  logic [W-1:0] r_res_prod, w_res_prod_next;
  logic         r_mul_start, w_mul_start_next;
  logic [W-1:0] r_mul_data, w_mul_data_next;
  logic         r_mul_restart, w_mul_restart_next;
  logic         w_accept;
  logic         w_zero_op;

  assign w_accept  = op_valid && r_op_ready;
  assign w_zero_op = (op_a == '0) || (op_b == '0);

`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_timer, w_timer_next;
  logic          r_res_err, w_res_err_next;
  logic          w_timeout;

  // Last WAIT cycle before abort: the counter started at 0 on WAIT entry
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  // Timer and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_res_err <= 1'b0;
    end else begin
      r_timer   <= w_timer_next;
      r_res_err <= w_res_err_next;
    end
  end

  assign res_err = r_res_err;
`else
  // No abort path: the engine is trusted to finish, so the error flag is constant
  assign res_err = 1'b0;

  // TIMEOUT has no effect in this build; a non-positive value is simply ignored
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // State and all output/operand registers; outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_used        <= 1'b0;
      r_op_ready    <= 1'b1;
      r_res_valid   <= 1'b0;
      r_res_prod    <= '0;
      r_mul_start   <= 1'b0;
      r_mul_data    <= '0;
      r_mul_restart <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_a           <= w_a_next;
      r_b           <= w_b_next;
      r_used        <= w_used_next;
      r_op_ready    <= w_op_ready_next;
      r_res_valid   <= w_res_valid_next;
      r_res_prod    <= w_res_prod_next;
      r_mul_start   <= w_mul_start_next;
      r_mul_data    <= w_mul_data_next;
      r_mul_restart <= w_mul_restart_next;
    end
  end

  // Next-state and next-output decode; every output is computed one cycle ahead
  always_comb begin
    w_state_next       = r_state;
    w_a_next           = r_a;
    w_b_next           = r_b;
    w_used_next        = r_used;
    w_op_ready_next    = r_op_ready;
    w_res_valid_next   = r_res_valid;
    w_res_prod_next    = r_res_prod;
    w_mul_start_next   = 1'b0;
    w_mul_data_next    = r_mul_data;
    w_mul_restart_next = 1'b0;
`ifdef MUL_TIMEOUT_EN
    w_timer_next       = r_timer;
    w_res_err_next     = r_res_err;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_a_next        = op_a;
          w_b_next        = op_b;
          w_op_ready_next = 1'b0;
`ifdef MUL_TIMEOUT_EN
          w_res_err_next  = 1'b0;
`endif
          if (w_zero_op) begin
            // Product is trivially zero; skip the engine entirely
            w_used_next      = 1'b0;
            w_res_prod_next  = '0;
            w_res_valid_next = 1'b1;
            w_state_next     = S_RESULT;
          end else begin
            w_used_next      = 1'b1;
            w_mul_start_next = 1'b1;
            w_mul_data_next  = op_a;
            w_state_next     = S_START;
          end
        end
      end

      S_START: begin
        // Engine moves to its ldA state on this edge; keep a on the bus
        w_mul_data_next = r_a;
        w_state_next    = S_LD_A;
      end

      S_LD_A: begin
        // Engine latches a on this edge; b must be on the bus for ldB next
        w_mul_data_next = r_b;
        w_state_next    = S_LD_B;
      end

      S_LD_B: begin
        w_mul_data_next = r_b;
`ifdef MUL_TIMEOUT_EN
        w_timer_next    = '0;
`endif
        w_state_next    = S_WAIT;
      end

      S_WAIT: begin
`ifdef MUL_TIMEOUT_EN
        w_timer_next = r_timer + TW'(1);
`endif
        if (mul_done) begin
          w_res_prod_next  = mul_prod;
          w_res_valid_next = 1'b1;
          w_state_next     = S_RESULT;
        end
`ifdef MUL_TIMEOUT_EN
        else if (w_timeout) begin
          w_res_prod_next  = '0;
          w_res_err_next   = 1'b1;
          w_res_valid_next = 1'b1;
          w_state_next     = S_RESULT;
        end
`endif
      end

      S_RESULT: begin
        if (res_ready) begin
          w_res_valid_next = 1'b0;
          if (r_used) begin
            w_mul_restart_next = 1'b1;
            w_state_next       = S_RESTART;
          end else begin
            w_op_ready_next = 1'b1;
            w_state_next    = S_IDLE;
          end
        end
      end

      S_RESTART: begin
        // Engine controller returns to S0 on this edge
        w_op_ready_next = 1'b1;
        w_state_next    = S_IDLE;
      end

      default: begin
        w_op_ready_next  = 1'b1;
        w_res_valid_next = 1'b0;
        w_state_next     = S_IDLE;
      end
    endcase
  end

  assign op_ready    = r_op_ready;
  assign res_valid   = r_res_valid;
  assign res_prod    = r_res_prod;
  assign mul_start   = r_mul_start;
  assign mul_data    = r_mul_data;
  assign mul_restart = r_mul_restart;

endmodule

// File: tb/tb_mul_op_sequencer.sv
// Self-checking bench for mul_op_sequencer with a behavioural multiplier engine.
// Build with MUL_TIMEOUT_EN defined to also cover the abort path (TIMEOUT=100).
module tb_mul_op_sequencer;
  localparam int W = 16;
`ifdef MUL_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65600;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_prod;
  logic         res_err;
  logic         mul_start;
  logic [W-1:0] mul_data;
  logic         mul_done;
  logic [W-1:0] mul_prod;
  logic         mul_restart;

  mul_op_sequencer #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod), .res_err(res_err),
    .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done),
    .mul_prod(mul_prod), .mul_restart(mul_restart)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural engine: load A, load B, add A into P B times
  typedef enum {E_S0, E_S1, E_S2, E_S3, E_S4} est_t;
  est_t         es;
  logic [W-1:0] ea, eb, ep;
  bit           eng_hang = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      es <= E_S0; ea <= '0; eb <= '0; ep <= '0;
    end else if (mul_restart) begin
      es <= E_S0;
    end else begin
      case (es)
        E_S0: if (mul_start) es <= E_S1;
        E_S1: begin ea <= mul_data; es <= E_S2; end
        E_S2: begin eb <= mul_data; ep <= '0; es <= E_S3; end
        E_S3: if (eb == '0) es <= E_S4; else begin ep <= ep + ea; eb <= eb - 1'b1; end
        default: ;
      endcase
    end
  end
  assign mul_done = (es == E_S4) && !eng_hang;
  assign mul_prod = ep;

  // ---------------- res_ready driver
  bit rr_mode = 0;   // 1: random back-pressure
  bit rr_val  = 1;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_mode) res_ready = ($urandom_range(0, 3) != 0);
      else         res_ready = rr_val;
    end
  end

  // ---------------- scoreboard
  typedef struct { logic [W-1:0] p; logic e; } exp_t;
  exp_t sb[$];
  int n_sent = 0, n_res = 0, n_start = 0, n_restart = 0;

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(res_prod), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result prod=%0d err=%0d (expected %0d/%0d)", res_prod, res_err, e.p, e.e);
        check("res_prod", 32'(res_prod), 32'(e.p));
        check("res_err", 32'(res_err), 32'(e.e));
      end
      n_res++;
    end
    if (rst_n && mul_start)   n_start++;
    if (rst_n && mul_restart) n_restart++;
  end

  // ---------------- stimulus helpers
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit exp_err);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 3000) begin @(negedge clk); n++; end
    if (!op_ready) begin
      check("op_ready_wait_expired", 0, 1);
      return;
    end
    op_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    e.p = exp_err ? '0 : W'(32'(a) * 32'(b));
    e.e = exp_err;
    sb.push_back(e);
    n_sent++;
    $display("op a=%0d b=%0d", a, b);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && op_ready && !res_valid) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) check("idle_wait_expired", 0, 1);
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_op_ready"},    32'(op_ready), 1);
    check({tag, "_res_valid"},   32'(res_valid), 0);
    check({tag, "_res_prod"},    32'(res_prod), 0);
    check({tag, "_res_err"},     32'(res_err), 0);
    check({tag, "_mul_start"},   32'(mul_start), 0);
    check({tag, "_mul_data"},    32'(mul_data), 0);
    check({tag, "_mul_restart"}, 32'(mul_restart), 0);
  endtask

  initial begin
    int s0, r0, n;
    // reset state
    #12;
    reset_outputs_check("reset");
    @(negedge clk); rst_n = 1'b1;

    // 7 x 5 with bus sequencing
    s0 = n_start; r0 = n_restart;
    send(7, 5, 0);
    check("start_cyc_mul_start", 32'(mul_start), 1);
    check("start_cyc_mul_data", 32'(mul_data), 7);
    @(posedge clk); #1;
    check("lda_cyc_mul_start", 32'(mul_start), 0);
    check("lda_cyc_mul_data", 32'(mul_data), 7);
    @(posedge clk); #1;
    check("ldb_cyc_mul_data", 32'(mul_data), 5);
    wait_idle();
    check("7x5_restart_pulses", 32'(n_restart - r0), 1);
    check("7x5_start_pulses", 32'(n_start - s0), 1);

    // zero operand: one-cycle result, engine untouched
    s0 = n_start; r0 = n_restart;
    send(0, 1234, 0);
    check("zero_res_valid_next_cycle", 32'(res_valid), 1);
    check("zero_op_ready_low", 32'(op_ready), 0);
    wait_idle();
    check("zero_no_start", 32'(n_start - s0), 0);
    check("zero_no_restart", 32'(n_restart - r0), 0);

    // truncation
    send(300, 300, 0);
    wait_idle();

    // back-pressure: hold res_ready low for 10 cycles
    rr_val = 0;
    send(11, 13, 0);
    n = 0;
    while (!res_valid && n < 500) begin @(negedge clk); n++; end
    check("stall_res_valid_seen", 32'(res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_res_prod_stable", 32'(res_prod), 143);
      check("stall_op_ready_low", 32'(op_ready), 0);
    end
    rr_val = 1;
    send(3, 4, 0);
    wait_idle();

    // asynchronous reset in the middle of WAIT
    send(9, 150, 0);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    reset_outputs_check("midwait_reset");
    sb.delete();
    n_sent = n_res;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_op_ready", 32'(op_ready), 1);

`ifdef MUL_TIMEOUT_EN
    // engine never reports done: abort after TIMEOUT WAIT cycles
    r0 = n_restart;
    eng_hang = 1;
    send(5, 6, 1);
    n = 0;
    while (!res_valid && n < 1000) begin @(posedge clk); #1; n++; end
    check("timeout_latency", 32'(n), 32'(3 + TO));
    check("timeout_res_err_flag", 32'(res_err), 1);
    wait_idle();
    eng_hang = 0;
    check("timeout_restart_pulse", 32'(n_restart - r0), 1);
    send(6, 7, 0);
    wait_idle();
`endif

    // randomized traffic with random back-pressure
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom_range(0, 60));
      if ($urandom_range(0, 7) == 0) a = '0;
      send(a, b, 0);
    end
    wait_idle();
    rr_mode = 0;

    check("all_results_returned", 32'(n_res), 32'(n_sent));
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_op_sequencer.md
Name: mul_op_sequencer

Overview:
- Upstream front-end for the repetitive-addition multiplier engine (controller plus MUL datapath).
- Accepts an operand pair over a valid/ready handshake and serialises it onto the engine's shared data bus: multiplicand during the engine's ldA cycle, multiplier during its ldB cycle.
- Waits for engine done, captures the product, and returns it over a second valid/ready handshake.
- Re-arms the engine with a restart pulse, because the engine controller parks in its final state.

Parameters:
- W, 16: operand/product width; must equal the engine data width.
- TIMEOUT, 65600: max cycles in WAIT before abort; must be at least 2^W + 64.

Ports:
- clk  input  1  rising-edge clock shared with the engine
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  operand pair valid
- op_ready  output  1  sequencer can accept a pair
- op_a  input  W  multiplicand
- op_b  input  W  multiplier
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_prod  output  W  product, low W bits
- res_err  output  1  result aborted by timeout (always 0 without MUL_TIMEOUT_EN)
- mul_start  output  1  to engine start
- mul_data  output  W  to engine data_in
- mul_done  input  1  from engine done
- mul_prod  input  W  engine product register tap
- mul_restart  output  1  one-cycle pulse returning engine controller to S0

Behaviour:
- Reset, asynchronous while rst_n=0:
  - State = IDLE.
  - op_ready=1, res_valid=0, res_prod=0, res_err=0.
  - mul_start=0, mul_data=0, mul_restart=0.
  - Captured operands and timer cleared.
- All outputs are registered.
- States: IDLE, START, LD_A, LD_B, WAIT, RESULT, RESTART.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready, latch op_a/op_b and drop op_ready the next cycle.
  - If a==0 or b==0, go to RESULT directly with res_prod=0; the engine is not touched.
  - Otherwise go to START.
- START (1 cycle): mul_start=1, mul_data=a.
- LD_A (1 cycle): mul_start=0, mul_data=a; the engine samples a on its ldA edge.
- LD_B (1 cycle): mul_data=b; the engine samples b on its ldB edge.
- WAIT:
  - mul_data holds b.
  - Remains here until mul_done=1.
  - On mul_done, register res_prod=mul_prod and go to RESULT.
  - mul_done is level-sensitive: the first cycle it is seen high counts.
- RESULT:
  - res_valid=1, with res_prod and res_err stable until res_ready.
  - On res_valid&res_ready, clear res_valid.
  - If the engine was used, go to RESTART; otherwise go to IDLE.
- RESTART (1 cycle): mul_restart=1, then go to IDLE.
- Latency: nonzero operands give minimum 4 + (engine done latency) cycles from op accept to res_valid. Zero operands give 1 cycle.
- One transaction in flight; op_ready=0 in every state except IDLE.
- mul_done asserted while in IDLE, START, LD_A or LD_B is ignored.
- res_ready held high gives back-to-back operation; no bubble beyond RESTART.
- Product is truncated to W bits (engine is W-bit); no overflow flag.
- Reset mid-transaction: outputs return to reset values immediately. The integrator must also reset or restart the engine; the sequencer does not pulse mul_restart on rst_n.

Optional Feature:
- MUL_TIMEOUT_EN defined:
  - WAIT runs a cycle counter cleared on WAIT entry.
  - Reaching TIMEOUT without mul_done goes to RESULT with res_prod=0, res_err=1, then RESTART as normal.
  - res_err is cleared on the next op accept.
- Not defined: no counter logic; res_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Reset with rst_n low mid-WAIT -> all outputs at reset values asynchronously; op_ready=1 after release.
- a=7, b=5 with behavioural engine model:
  - mul_data=7 in START/LD_A, then 5 in LD_B.
  - res_prod=35, res_err=0.
  - One mul_restart pulse after the handshake.
- a=0, b=1234 -> res_valid one cycle after accept, res_prod=0, mul_start never asserted.
- a=300, b=300 -> res_prod=90000 mod 65536 = 24464.
- res_ready held 0 for 10 cycles after res_valid -> res_prod stable, op_ready=0 throughout; accept on release, then next pair 3×4 -> 12.
- With MUL_TIMEOUT_EN and TIMEOUT=100, engine model never asserts done -> res_valid at WAIT+100 cycles, res_err=1, res_prod=0, mul_restart pulsed.
